// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side controller: RAM status, word and core-index types,
// and the arbiter state encoding.
package cpu_types_pkg;

  localparam int NCPU      = 2;
  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0]    word_t;
  typedef logic [$clog2(NCPU)-1:0] cpu_idx_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response bundle plus the single-ported RAM bus.
// The slave modport is the arbiter's view; master is the caches/RAM side.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = NCPU,
  parameter int WORD_W = WORD_BITS
);

  logic [CPUS-1:0]        iREN;
  logic [CPUS*WORD_W-1:0] iaddr;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*WORD_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  ramstate_t              ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: returns the first requester strictly after 'last',
// wrapping around, so the previous winner has lowest priority.
module rr_pick #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    valid = 1'b0;
    idx   = '0;
    // Walk from farthest to nearest so the nearest requester is written last and wins.
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        valid = 1'b1;
        idx   = W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache traffic from all cores onto one RAM port; data beats
// instruction, round-robin within each class, grant held for the whole block transfer.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = NCPU,
  parameter int WORD_W = WORD_BITS
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  localparam int               IDX_W     = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(CPUS - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] gsel;
  logic [IDX_W-1:0] d_last;
  logic [IDX_W-1:0] i_last;
  logic [IDX_W-1:0] d_pick;
  logic [IDX_W-1:0] i_pick;
  logic             d_valid;
  logic             i_valid;
  logic [CPUS-1:0]  d_req;
  logic             access;

  assign d_req  = bus.dREN | bus.dWEN;
  assign access = (bus.ramstate == ACCESS);

  rr_pick #(.N(CPUS)) u_dpick (
    .req   (d_req),
    .last  (d_last),
    .valid (d_valid),
    .idx   (d_pick)
  );

  rr_pick #(.N(CPUS)) u_ipick (
    .req   (bus.iREN),
    .last  (i_last),
    .valid (i_valid),
    .idx   (i_pick)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      gsel   <= '0;
      d_last <= LAST_INIT;
      i_last <= LAST_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            state <= DGRANT;
            gsel  <= d_pick;
          end else if (i_valid) begin
            state <= IGRANT;
            gsel  <= i_pick;
          end
        end
        // Grant is held until the owner drops its enable; the pointer only moves on release.
        DGRANT: begin
          if (!d_req[gsel]) begin
            state  <= IDLE;
            d_last <= gsel;
          end
        end
        IGRANT: begin
          if (!bus.iREN[gsel]) begin
            state  <= IDLE;
            i_last <= gsel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Wait outputs depend on ramstate only, never on ramload; BUSY/FREE/ERROR all keep wait high.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      DGRANT: begin
        bus.ramaddr                            = bus.daddr[int'(gsel)*WORD_W +: WORD_W];
        bus.ramstore                           = bus.dstore[int'(gsel)*WORD_W +: WORD_W];
        bus.ramWEN                             = bus.dWEN[gsel];
        bus.ramREN                             = bus.dREN[gsel] & ~bus.dWEN[gsel];
        bus.dwait[gsel]                        = ~access;
        bus.dload[int'(gsel)*WORD_W +: WORD_W] = bus.ramload;
      end
      IGRANT: begin
        bus.ramaddr                            = bus.iaddr[int'(gsel)*WORD_W +: WORD_W];
        bus.ramREN                             = bus.iREN[gsel];
        bus.iwait[gsel]                        = ~access;
        bus.iload[int'(gsel)*WORD_W +: WORD_W] = bus.ramload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, hand-written corner sequences, then
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int WW   = 32;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.CPUS(CPUS), .WORD_W(WW)) bus ();

  mem_arbiter #(.CPUS(CPUS), .WORD_W(WW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  iren, dren, dwen;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  rst;
    logic [31:0] rload;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic [1:0]  e_iw, e_dw;
    logic [63:0] e_il, e_dl;
  } vec_t;

  vec_t tv[16];

  // Reference model: who owns the RAM (0 none, 1 data, 2 instruction) and the last winners.
  int m_kind, m_own, m_dlast, m_ilast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ren, input logic wen,
                            input logic [31:0] addr, input logic [31:0] store,
                            input logic [1:0] iw, input logic [1:0] dw,
                            input logic [63:0] il, input logic [63:0] dl);
    check({tag, ".ramREN"},   bus.ramREN,   ren);
    check({tag, ".ramWEN"},   bus.ramWEN,   wen);
    check({tag, ".ramaddr"},  bus.ramaddr,  addr);
    check({tag, ".ramstore"}, bus.ramstore, store);
    check({tag, ".iwait"},    bus.iwait,    iw);
    check({tag, ".dwait"},    bus.dwait,    dw);
    check({tag, ".iload"},    bus.iload,    il);
    check({tag, ".dload"},    bus.dload,    dl);
  endtask

  task automatic drive(input logic [1:0] iren, input logic [1:0] dren, input logic [1:0] dwen,
                       input logic [63:0] iaddr, input logic [63:0] daddr,
                       input logic [63:0] dstore, input logic [1:0] rst,
                       input logic [31:0] rload);
    bus.iREN     = iren;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.iaddr    = iaddr;
    bus.daddr    = daddr;
    bus.dstore   = dstore;
    bus.ramstate = ramstate_t'(rst);
    bus.ramload  = rload;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int rr_next(input int last, input logic [1:0] req);
    for (int k = 1; k <= CPUS; k++) begin
      int c = (last + k) % CPUS;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset;
    m_kind  = 0;
    m_own   = 0;
    m_dlast = CPUS - 1;
    m_ilast = CPUS - 1;
  endtask

  task automatic model_check(input string tag);
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [1:0]  iw, dw;
    logic [63:0] il, dl;
    ren = 0; wen = 0; addr = 0; store = 0; iw = '1; dw = '1; il = 0; dl = 0;
    if (m_kind == 1) begin
      addr  = bus.daddr[m_own*32 +: 32];
      store = bus.dstore[m_own*32 +: 32];
      wen   = bus.dWEN[m_own];
      ren   = bus.dREN[m_own] && !bus.dWEN[m_own];
      if (bus.ramstate == ACCESS) dw[m_own] = 1'b0;
      dl[m_own*32 +: 32] = bus.ramload;
    end else if (m_kind == 2) begin
      addr = bus.iaddr[m_own*32 +: 32];
      ren  = bus.iREN[m_own];
      if (bus.ramstate == ACCESS) iw[m_own] = 1'b0;
      il[m_own*32 +: 32] = bus.ramload;
    end
    check_outs(tag, ren, wen, addr, store, iw, dw, il, dl);
  endtask

  task automatic model_update;
    logic [1:0] dreq;
    dreq = bus.dREN | bus.dWEN;
    if (m_kind == 0) begin
      if (dreq != 0) begin
        m_kind = 1;
        m_own  = rr_next(m_dlast, dreq);
      end else if (bus.iREN != 0) begin
        m_kind = 2;
        m_own  = rr_next(m_ilast, bus.iREN);
      end
    end else if (m_kind == 1 && !dreq[m_own]) begin
      m_kind  = 0;
      m_dlast = m_own;
    end else if (m_kind == 2 && !bus.iREN[m_own]) begin
      m_kind  = 0;
      m_ilast = m_own;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] rnd_i, rnd_d, rnd_w;

    //        iren  dren  dwen  iaddr        daddr                  dstore                 rst   rload          ren wen addr           store          iw     dw     iload          dload
    tv[0]  = '{2'b00,2'b01,2'b00,64'h0,       64'h40,                64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[1]  = '{2'b00,2'b01,2'b00,64'h0,       64'h40,                64'h0,                 2'd2, 32'hDEADBEEF,  1'b1,1'b0,32'h40,       32'h0,         2'b11,2'b10,64'h0,         64'hDEADBEEF};
    tv[2]  = '{2'b00,2'b01,2'b00,64'h0,       64'h44,                64'h0,                 2'd2, 32'h12345678,  1'b1,1'b0,32'h44,       32'h0,         2'b11,2'b10,64'h0,         64'h12345678};
    tv[3]  = '{2'b00,2'b00,2'b00,64'h0,       64'h44,                64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h44,       32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[4]  = '{2'b00,2'b00,2'b00,64'h0,       64'h0,                 64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[5]  = '{2'b01,2'b00,2'b10,64'h200,     64'h00000100_00000000, 64'hAAAA5555_00000000, 2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[6]  = '{2'b01,2'b00,2'b10,64'h200,     64'h00000100_00000000, 64'hAAAA5555_00000000, 2'd2, 32'h0,         1'b0,1'b1,32'h100,      32'hAAAA5555,  2'b11,2'b01,64'h0,         64'h0};
    tv[7]  = '{2'b01,2'b00,2'b00,64'h200,     64'h00000100_00000000, 64'hAAAA5555_00000000, 2'd0, 32'h0,         1'b0,1'b0,32'h100,      32'hAAAA5555,  2'b11,2'b11,64'h0,         64'h0};
    tv[8]  = '{2'b01,2'b00,2'b00,64'h200,     64'h0,                 64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[9]  = '{2'b01,2'b00,2'b00,64'h200,     64'h0,                 64'h0,                 2'd2, 32'hCAFEF00D,  1'b1,1'b0,32'h200,      32'h0,         2'b10,2'b11,64'hCAFEF00D,  64'h0};
    tv[10] = '{2'b00,2'b00,2'b00,64'h200,     64'h0,                 64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h200,      32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[11] = '{2'b00,2'b00,2'b00,64'h0,       64'h0,                 64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[12] = '{2'b00,2'b01,2'b01,64'h0,       64'h80,                64'h11112222,          2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};
    tv[13] = '{2'b00,2'b01,2'b01,64'h0,       64'h80,                64'h11112222,          2'd2, 32'h0,         1'b0,1'b1,32'h80,       32'h11112222,  2'b11,2'b10,64'h0,         64'h0};
    tv[14] = '{2'b00,2'b00,2'b00,64'h0,       64'h80,                64'h11112222,          2'd0, 32'h0,         1'b0,1'b0,32'h80,       32'h11112222,  2'b11,2'b11,64'h0,         64'h0};
    tv[15] = '{2'b00,2'b00,2'b00,64'h0,       64'h0,                 64'h0,                 2'd0, 32'h0,         1'b0,1'b0,32'h0,        32'h0,         2'b11,2'b11,64'h0,         64'h0};

    nRST = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 2'd0, 32'h0);
    #2;
    check_outs("reset", 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11, 64'h0, 64'h0);
    tick;
    nRST = 1'b1;

    // Directed cycle table: single-core block read, write beating a pending fetch, REN+WEN.
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].iren, tv[i].dren, tv[i].dwen, tv[i].iaddr, tv[i].daddr, tv[i].dstore,
            tv[i].rst, tv[i].rload);
      @(negedge CLK);
      check_outs($sformatf("vec%0d", i), tv[i].e_ren, tv[i].e_wen, tv[i].e_addr, tv[i].e_store,
                 tv[i].e_iw, tv[i].e_dw, tv[i].e_il, tv[i].e_dl);
      tick;
    end

    // Reset in the middle of a data grant; the data pointer was left at core 0.
    drive(2'b00, 2'b01, 2'b00, 64'h0, 64'h500, 64'h0, 2'd0, 32'h0);
    tick;
    @(negedge CLK);
    check("mid_dgrant.ramREN", bus.ramREN, 1'b1);
    nRST = 1'b0;
    #1;
    check_outs("mid_reset", 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11, 64'h0, 64'h0);
    tick;
    nRST = 1'b1;

    // Both cores request twice: core 0 first after reset, then core 1.
    drive(2'b00, 2'b11, 2'b00, 64'h0, 64'h00000020_00000010, 64'h0, 2'd0, 32'h0);
    @(negedge CLK);
    check("rr.idle.ramREN", bus.ramREN, 1'b0);
    tick;
    drive(2'b00, 2'b11, 2'b00, 64'h0, 64'h00000020_00000010, 64'h0, 2'd2, 32'h0);
    @(negedge CLK);
    check("rr.first.ramaddr", bus.ramaddr, 32'h10);
    check("rr.first.dwait", bus.dwait, 2'b10);
    tick;
    drive(2'b00, 2'b10, 2'b00, 64'h0, 64'h00000020_00000010, 64'h0, 2'd0, 32'h0);
    tick;
    drive(2'b00, 2'b11, 2'b00, 64'h0, 64'h00000020_00000010, 64'h0, 2'd0, 32'h0);
    @(negedge CLK);
    check("rr.idle2.ramREN", bus.ramREN, 1'b0);
    tick;
    drive(2'b00, 2'b11, 2'b00, 64'h0, 64'h00000020_00000010, 64'h0, 2'd2, 32'h0);
    @(negedge CLK);
    check("rr.second.ramaddr", bus.ramaddr, 32'h20);
    check("rr.second.dwait", bus.dwait, 2'b01);
    tick;
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 2'd0, 32'h0);
    tick;
    tick;

    // RAM stalls: BUSY x3, ERROR x1, then ACCESS.
    drive(2'b00, 2'b10, 2'b00, 64'h0, 64'h00000300_00000000, 64'h0, 2'd0, 32'h0);
    tick;
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'b10, 2'b00, 64'h0, 64'h00000300_00000000, 64'h0,
            (k < 3) ? 2'd1 : 2'd3, 32'h0);
      @(negedge CLK);
      check($sformatf("stall%0d.dwait", k), bus.dwait, 2'b11);
      check($sformatf("stall%0d.ramaddr", k), bus.ramaddr, 32'h300);
      check($sformatf("stall%0d.ramREN", k), bus.ramREN, 1'b1);
      tick;
    end
    drive(2'b00, 2'b10, 2'b00, 64'h0, 64'h00000300_00000000, 64'h0, 2'd2, 32'h0);
    @(negedge CLK);
    check("stall.access.dwait", bus.dwait, 2'b01);
    check("stall.access.ramaddr", bus.ramaddr, 32'h300);
    tick;
    drive(2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 2'd0, 32'h0);
    tick;

    // Randomized traffic against the reference model, with occasional resets.
    nRST = 1'b0;
    model_reset();
    tick;
    nRST = 1'b1;
    rnd_i = 0; rnd_d = 0; rnd_w = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 9) >= 7) rnd_i[c] = ~rnd_i[c];
        if ($urandom_range(0, 9) >= 7) rnd_d[c] = ~rnd_d[c];
        if ($urandom_range(0, 9) >= 8) rnd_w[c] = ~rnd_w[c];
      end
      nRST = ($urandom_range(0, 63) != 0);
      if (!nRST) model_reset();
      drive(rnd_i, rnd_d, rnd_w, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom);
      @(negedge CLK);
      model_check($sformatf("rand%0d", cyc));
      if (nRST) model_update();
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
